// File: rtl/cnn_weight_pkg.sv
// Shared definitions for the CNN weight streaming path.
// Holds the weight/word geometry, the streamer FSM state encoding and a
// helper that converts a weight count into a ROM word count.
package cnn_weight_pkg;

  localparam int W_WIDTH        = 16;
  localparam int DATA_WIDTH     = 128;
  localparam int LANES_PER_WORD = DATA_WIDTH / W_WIDTH;
  localparam int PAIR_LANES     = 2 * LANES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    STREAM,
    DONE
  } state_t;

  function automatic int words_needed(input int n);
    return (n + LANES_PER_WORD - 1) / LANES_PER_WORD;
  endfunction

endpackage

// File: rtl/weight_rom_streamer.sv
// Streams packed signed weights out of a registered dual-port weight ROM,
// one weight per valid/ready handshake. Each refill fetches an even/odd
// word pair (port A even, port B odd); the following pair is addressed as
// soon as the current one is captured, so it is ready long before the
// current pair drains and pair boundaries cost no bubble.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 single-cycle run request, ignored while busy
//   busy, done            run in progress / one-cycle completion pulse
//   rom_addr_a/b          registered even/odd word addresses
//   rom_q_a/b             ROM read data, one cycle after the address
//   w_data, w_valid       current weight and its valid flag
//   w_ready               consumer accept
//   w_last, w_index       final-weight flag and 0-based weight index
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start, addresses parked at word 0/1
// FILL   | ROM read of the first pair in flight
// LOAD   | capture first pair, address the next pair
// STREAM | present one lane per handshake, reload on lane 15
// DONE   | one-cycle done pulse
module weight_rom_streamer
  import cnn_weight_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_WEIGHTS = 122
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr_a,
  output logic [ADDR_WIDTH-1:0] rom_addr_b,
  input  logic [DATA_WIDTH-1:0] rom_q_a,
  input  logic [DATA_WIDTH-1:0] rom_q_b,
  output logic [W_WIDTH-1:0]    w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last,
  output logic [7:0]            w_index
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int WORDS  = words_needed(NUM_WEIGHTS);
  localparam int LANE_W = $clog2(PAIR_LANES);
  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(PAIR_LANES - 1);
  localparam logic [7:0]        LAST_IDX = 8'(NUM_WEIGHTS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [PAIR_W-1:0]   pair_buf;
  logic [LANE_W-1:0]   lane;
  logic                hs;
  logic                at_last;
  logic                has_next;
  logic [ADDR_WIDTH-1:0] next_a;
  logic [ADDR_WIDTH-1:0] next_b;

  assign hs       = (state == STREAM) && w_ready;
  assign at_last  = (w_index == LAST_IDX);
  // Another pair exists only if its even word still holds weights.
  assign has_next = (int'(rom_addr_a) + 2) < WORDS;
  assign next_a   = rom_addr_a + ADDR_WIDTH'(2);
  // Odd address saturates so an odd word count never wraps past the ROM.
  assign next_b   = ((int'(rom_addr_a) + 3) > (DEPTH - 1)) ?
                    ADDR_WIDTH'(DEPTH - 1) : rom_addr_a + ADDR_WIDTH'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    state_nxt = LOAD;
      LOAD:    state_nxt = STREAM;
      STREAM:  if (hs && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    w_valid = 1'b0;
    case (state)
      FILL, LOAD: busy = 1'b1;
      STREAM: begin
        busy    = 1'b1;
        w_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    w_last = w_valid && at_last;
  end

  // Lane 0 sits in the most significant slot of {rom_q_a, rom_q_b}.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < PAIR_LANES; i++) begin
      if (lane == LANE_W'(i)) w_data = pair_buf[PAIR_W-1-i*W_WIDTH -: W_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_buf   <= '0;
      lane       <= '0;
      w_index    <= '0;
      rom_addr_a <= '0;
      rom_addr_b <= ADDR_WIDTH'(1);
    end else begin
      case (state)
        IDLE: begin
          rom_addr_a <= '0;
          rom_addr_b <= ADDR_WIDTH'(1);
        end
        LOAD: begin
          pair_buf <= {rom_q_a, rom_q_b};
          lane     <= '0;
          w_index  <= '0;
          if (has_next) begin
            rom_addr_a <= next_a;
            rom_addr_b <= next_b;
          end
        end
        STREAM: begin
          if (hs && !at_last) begin
            w_index <= w_index + 8'd1;
            if (lane == LANE_MAX) begin
              // Prefetched pair has been addressed for 16+ cycles.
              pair_buf <= {rom_q_a, rom_q_b};
              lane     <= '0;
              if (has_next) begin
                rom_addr_a <= next_a;
                rom_addr_b <= next_b;
              end
            end else begin
              lane <= lane + LANE_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_rom_streamer.sv
// Bench for weight_rom_streamer: a bench-owned layer-0 ROM image feeds two
// instances (122 weights and 8 weights) through registered read ports.
// Expected handshakes are queued when a run is started and popped as the
// design hands weights over.
module tb_weight_rom_streamer;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n, start, w_ready, start8, ready8;
  logic [127:0] rom_mem [16];
  logic [3:0]   addr_a, addr_b, addr_a8, addr_b8;
  logic [127:0] q_a, q_b, q_a8, q_b8;
  logic busy, done, w_valid, w_last;
  logic [15:0] w_data;
  logic [7:0]  w_index;
  logic busy8, done8, w_valid8, w_last8;
  logic [15:0] w_data8;
  logic [7:0]  w_index8;

  int total = 0;
  int bad = 0;
  exp_t sbq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    q_a  <= rom_mem[addr_a];
    q_b  <= rom_mem[addr_b];
    q_a8 <= rom_mem[addr_a8];
    q_b8 <= rom_mem[addr_b8];
  end

  weight_rom_streamer #(.ADDR_WIDTH(4), .NUM_WEIGHTS(122)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_addr_a(addr_a), .rom_addr_b(addr_b), .rom_q_a(q_a), .rom_q_b(q_b),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .w_last(w_last), .w_index(w_index)
  );

  weight_rom_streamer #(.ADDR_WIDTH(4), .NUM_WEIGHTS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
    .rom_addr_a(addr_a8), .rom_addr_b(addr_b8), .rom_q_a(q_a8), .rom_q_b(q_b8),
    .w_data(w_data8), .w_valid(w_valid8), .w_ready(ready8),
    .w_last(w_last8), .w_index(w_index8)
  );

  function automatic logic [15:0] rom_w(input int n);
    return rom_mem[n/8][127 - 16*(n%8) -: 16];
  endfunction

  task automatic set_w(input int n, input logic [15:0] v);
    rom_mem[n/8][127 - 16*(n%8) -: 16] = v;
  endtask

  task automatic fill_rom();
    for (int n = 0; n < 128; n++) set_w(n, 16'((n * 40503 + 777) ^ (n << 9)));
    set_w(0, 16'hfe74);   set_w(1, 16'hfbb1);   set_w(2, 16'hf13c);
    set_w(7, 16'h14cc);   set_w(8, 16'h0026);   set_w(15, 16'h0658);
    set_w(16, 16'hfd57);  set_w(120, 16'h021e); set_w(121, 16'hf901);
  endtask

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++)
      sbq.push_back('{d: rom_w(i), idx: 8'(i), last: (i == n - 1)});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; w_ready = 1'b0; start8 = 1'b0; ready8 = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", w_valid); end
    total++; if (w_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", w_last); end
    total++; if (w_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", w_data); end
    total++; if (w_index !== 8'h0) begin bad++; $display("FAIL reset_index got=%0d exp=0", w_index); end
    total++; if (addr_a !== 4'd0) begin bad++; $display("FAIL reset_addr_a got=%0d exp=0", addr_a); end
    total++; if (addr_b !== 4'd1) begin bad++; $display("FAIL reset_addr_b got=%0d exp=1", addr_b); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || w_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b valid=%b exp 0 0", busy, w_valid); end
  endtask

  task automatic test_full_run();
    exp_t e;
    int cyc, hs_n, first_hs, last_hs, first_valid, done_n, done_cyc;
    logic [15:0] obs [122];
    sbq.delete(); push_run(122);
    w_ready = 1'b1;
    start = 1'b1;
    cyc = 0; hs_n = 0; first_hs = -1; last_hs = -1; first_valid = -1; done_n = 0; done_cyc = -1;
    while (done_n == 0 && cyc < 400) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (cyc == 1) begin
        total++; if (addr_a !== 4'd0 || addr_b !== 4'd1 || busy !== 1'b1) begin bad++; $display("FAIL full_fill a=%0d b=%0d busy=%b exp 0 1 1", addr_a, addr_b, busy); end
      end
      if (cyc == 3) begin
        total++; if (addr_a !== 4'd2 || addr_b !== 4'd3) begin bad++; $display("FAIL full_prefetch a=%0d b=%0d exp 2 3", addr_a, addr_b); end
      end
      if (w_valid && first_valid < 0) first_valid = cyc;
      if (w_valid && w_ready) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL full_extra idx=%0d exp none", w_index); end
        else begin
          e = sbq.pop_front();
          if (w_data !== e.d || w_index !== e.idx || w_last !== e.last) begin
            bad++; $display("FAIL full_hs got d=%h i=%0d l=%b exp d=%h i=%0d l=%b", w_data, w_index, w_last, e.d, e.idx, e.last);
          end
        end
        if (w_index < 122) obs[w_index] = w_data;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc; hs_n++;
      end
      if (done) begin
        done_n++; done_cyc = cyc;
        total++; if (busy !== 1'b0 || addr_a !== 4'd14 || addr_b !== 4'd15) begin bad++; $display("FAIL full_done_state busy=%b a=%0d b=%0d exp 0 14 15", busy, addr_a, addr_b); end
      end
    end
    repeat (3) begin @(negedge clk); if (done) done_n++; end
    total++; if (first_valid != 3) begin bad++; $display("FAIL full_latency got=%0d exp=3", first_valid); end
    total++; if (hs_n != 122) begin bad++; $display("FAIL full_count got=%0d exp=122", hs_n); end
    total++; if (last_hs - first_hs != 121) begin bad++; $display("FAIL full_throughput span=%0d exp=121", last_hs - first_hs); end
    total++; if (done_n != 1) begin bad++; $display("FAIL full_done_pulses got=%0d exp=1", done_n); end
    total++; if (done_cyc != 125) begin bad++; $display("FAIL full_done_time got=%0d exp=125", done_cyc); end
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL full_missing left=%0d exp=0", sbq.size()); end
    total++; if (obs[0] !== 16'hfe74) begin bad++; $display("FAIL w0 got=%h exp=fe74", obs[0]); end
    total++; if (obs[1] !== 16'hfbb1) begin bad++; $display("FAIL w1 got=%h exp=fbb1", obs[1]); end
    total++; if (obs[2] !== 16'hf13c) begin bad++; $display("FAIL w2 got=%h exp=f13c", obs[2]); end
    total++; if (obs[8] !== 16'h0026) begin bad++; $display("FAIL w8 got=%h exp=0026", obs[8]); end
    total++; if (obs[120] !== 16'h021e) begin bad++; $display("FAIL w120 got=%h exp=021e", obs[120]); end
    total++; if (obs[121] !== 16'hf901) begin bad++; $display("FAIL w121 got=%h exp=f901", obs[121]); end
  endtask

  task automatic test_random_ready();
    exp_t e;
    int cyc, hs_n, done_n;
    logic prev_stall;
    logic [15:0] prev_d;
    logic [7:0] prev_i;
    logic prev_l;
    logic [15:0] obs [122];
    sbq.delete(); push_run(122);
    w_ready = 1'b0;
    start = 1'b1;
    cyc = 0; hs_n = 0; done_n = 0; prev_stall = 1'b0; prev_d = '0; prev_i = '0; prev_l = 1'b0;
    while (done_n == 0 && cyc < 2000) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (prev_stall) begin
        total++;
        if (w_valid !== 1'b1 || w_data !== prev_d || w_index !== prev_i || w_last !== prev_l) begin
          bad++; $display("FAIL stall_hold got v=%b d=%h i=%0d l=%b exp v=1 d=%h i=%0d l=%b", w_valid, w_data, w_index, w_last, prev_d, prev_i, prev_l);
        end
      end
      w_ready = 1'($urandom_range(0, 1));
      if (w_valid && w_ready) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL rand_extra idx=%0d exp none", w_index); end
        else begin
          e = sbq.pop_front();
          if (w_data !== e.d || w_index !== e.idx || w_last !== e.last) begin
            bad++; $display("FAIL rand_hs got d=%h i=%0d l=%b exp d=%h i=%0d l=%b", w_data, w_index, w_last, e.d, e.idx, e.last);
          end
        end
        if (w_index < 122) obs[w_index] = w_data;
        hs_n++;
      end
      prev_stall = w_valid && !w_ready;
      prev_d = w_data; prev_i = w_index; prev_l = w_last;
      if (done) done_n++;
    end
    w_ready = 1'b1;
    repeat (3) begin @(negedge clk); if (done) done_n++; end
    total++; if (hs_n != 122) begin bad++; $display("FAIL rand_count got=%0d exp=122", hs_n); end
    total++; if (done_n != 1) begin bad++; $display("FAIL rand_done_pulses got=%0d exp=1", done_n); end
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL rand_missing left=%0d exp=0", sbq.size()); end
    total++; if (obs[15] !== 16'h0658 || obs[16] !== 16'hfd57) begin bad++; $display("FAIL rand_boundary got=%h %h exp=0658 fd57", obs[15], obs[16]); end
  endtask

  task automatic test_restart_ignored();
    exp_t e;
    int cyc, hs_n, done_n, done_cyc;
    sbq.delete(); push_run(122);
    w_ready = 1'b1;
    start = 1'b1;
    cyc = 0; hs_n = 0; done_n = 0; done_cyc = -1;
    while (done_n == 0 && cyc < 400) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (w_valid && w_ready) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL restart_extra idx=%0d exp none", w_index); end
        else begin
          e = sbq.pop_front();
          if (w_data !== e.d || w_index !== e.idx || w_last !== e.last) begin
            bad++; $display("FAIL restart_hs got d=%h i=%0d l=%b exp d=%h i=%0d l=%b", w_data, w_index, w_last, e.d, e.idx, e.last);
          end
        end
        if (w_index == 8'd40) start = 1'b1;
        hs_n++;
      end
      if (done) begin done_n++; done_cyc = cyc; end
    end
    repeat (3) begin @(negedge clk); if (done) done_n++; end
    total++; if (hs_n != 122) begin bad++; $display("FAIL restart_count got=%0d exp=122", hs_n); end
    total++; if (done_n != 1) begin bad++; $display("FAIL restart_done_pulses got=%0d exp=1", done_n); end
    total++; if (done_cyc != 125) begin bad++; $display("FAIL restart_done_time got=%0d exp=125", done_cyc); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int cyc, done_n, hs_n;
    logic hit;
    logic [15:0] first_d;
    sbq.delete(); push_run(122);
    w_ready = 1'b1;
    start = 1'b1;
    cyc = 0; hit = 1'b0; done_n = 0;
    while (!hit && cyc < 400) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (done) done_n++;
      if (w_valid && w_ready && w_index == 8'd60) begin
        total++;
        e = sbq[60];
        if (w_data !== e.d) begin bad++; $display("FAIL areset_w60 got=%h exp=%h", w_data, e.d); end
        hit = 1'b1;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL areset_reach got=%b exp=1", hit); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || w_valid !== 1'b0 || w_last !== 1'b0) begin
      bad++; $display("FAIL areset_flags busy=%b done=%b valid=%b last=%b exp 0 0 0 0", busy, done, w_valid, w_last);
    end
    total++; if (w_data !== 16'h0 || w_index !== 8'h0) begin bad++; $display("FAIL areset_data d=%h i=%0d exp 0 0", w_data, w_index); end
    total++; if (addr_a !== 4'd0 || addr_b !== 4'd1) begin bad++; $display("FAIL areset_addr a=%0d b=%0d exp 0 1", addr_a, addr_b); end
    repeat (2) begin @(negedge clk); if (done) done_n++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) done_n++; end
    total++; if (done_n != 0) begin bad++; $display("FAIL areset_no_done got=%0d exp=0", done_n); end
    sbq.delete(); push_run(122);
    start = 1'b1;
    cyc = 0; hs_n = 0; first_d = 'x;
    while (done_n == 0 && cyc < 400) begin
      @(negedge clk); cyc++; start = 1'b0;
      if (w_valid && w_ready) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL areset_extra idx=%0d exp none", w_index); end
        else begin
          e = sbq.pop_front();
          if (w_data !== e.d || w_index !== e.idx || w_last !== e.last) begin
            bad++; $display("FAIL areset_hs got d=%h i=%0d l=%b exp d=%h i=%0d l=%b", w_data, w_index, w_last, e.d, e.idx, e.last);
          end
        end
        if (hs_n == 0) first_d = w_data;
        hs_n++;
      end
      if (done) done_n++;
    end
    total++; if (first_d !== 16'hfe74) begin bad++; $display("FAIL areset_restart_w0 got=%h exp=fe74", first_d); end
    total++; if (hs_n != 122 || done_n != 1) begin bad++; $display("FAIL areset_rerun hs=%0d done=%0d exp 122 1", hs_n, done_n); end
  endtask

  task automatic test_single_word();
    exp_t e;
    int cyc, hs_n, done_n, done_cyc;
    logic addr_ok;
    logic [15:0] last_d;
    sbq.delete(); push_run(8);
    ready8 = 1'b1;
    start8 = 1'b1;
    cyc = 0; hs_n = 0; done_n = 0; done_cyc = -1; addr_ok = 1'b1; last_d = 'x;
    while (done_n == 0 && cyc < 60) begin
      @(negedge clk); cyc++; start8 = 1'b0;
      if (busy8 && (addr_a8 !== 4'd0 || addr_b8 !== 4'd1)) addr_ok = 1'b0;
      if (w_valid8 && ready8) begin
        total++;
        if (sbq.size() == 0) begin bad++; $display("FAIL single_extra idx=%0d exp none", w_index8); end
        else begin
          e = sbq.pop_front();
          if (w_data8 !== e.d || w_index8 !== e.idx || w_last8 !== e.last) begin
            bad++; $display("FAIL single_hs got d=%h i=%0d l=%b exp d=%h i=%0d l=%b", w_data8, w_index8, w_last8, e.d, e.idx, e.last);
          end
        end
        if (w_last8) last_d = w_data8;
        hs_n++;
      end
      if (done8) begin done_n++; done_cyc = cyc; end
    end
    repeat (3) begin @(negedge clk); if (done8) done_n++; end
    total++; if (hs_n != 8) begin bad++; $display("FAIL single_count got=%0d exp=8", hs_n); end
    total++; if (last_d !== 16'h14cc) begin bad++; $display("FAIL single_last got=%h exp=14cc", last_d); end
    total++; if (done_n != 1 || done_cyc != 11) begin bad++; $display("FAIL single_done pulses=%0d at=%0d exp 1 11", done_n, done_cyc); end
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL single_addr got=moved exp=held 0 1"); end
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_full_run();
    test_random_ready();
    test_restart_ignored();
    test_async_reset();
    test_single_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
